program_sequencer_stack: RTL and testbench
==========================================

Name: program_sequencer_stack

Overview:
Parametrised next-generation program sequencer for the microprocessor front end. It produces the program-memory address each cycle and registers it as the PC. Over the base sequencer it adds:
- configurable address and jump-field widths
- a hardware call/return stack with overflow/underflow flags
- a stall (hold) input

It sits between the instruction decoder (jump/call/ret controls) and program memory.

Parameters:
ADDR_W, 8, width of pm_addr/pc/from_PS in bits
JMP_W, 4, width of jmp_addr field; jump target = {jmp_addr, (ADDR_W-JMP_W) zeros}; legal range 1..ADDR_W
STACK_DEPTH, 4, number of return-address entries; legal range 1..16

Ports:
clk  input  1  system clock, all state updates on rising edge
sync_reset_n  input  1  synchronous reset, active-low
jmp_addr  input  JMP_W  jump/call target field from decoder
jmp  input  1  unconditional jump
jmp_nz  input  1  conditional jump, taken when dont_jmp=0
dont_jmp  input  1  condition-false flag from ALU (zero flag)
call  input  1  call: push return address, branch to target
ret  input  1  return: pop return address, branch to it
hold  input  1  stall: PC holds, no stack change
pm_addr  output  ADDR_W  combinational next program-memory address
pc  output  ADDR_W  registered current PC
from_PS  output  ADDR_W  copy of pc for datapath
stack_level  output  $clog2(STACK_DEPTH+1)  entries currently on stack
stack_overflow  output  1  sticky: call attempted while full
stack_underflow  output  1  sticky: ret attempted while empty

Behaviour:
- Registers
  - pc <= pm_addr every rising edge. There is no enable; hold acts through pm_addr.
  - from_PS = pc, combinational.
- Jump target T = {jmp_addr, {ADDR_W-JMP_W{1'b0}}}.
- pm_addr is combinational. Priority, highest first:
  1. sync_reset_n=0: pm_addr=0
  2. hold=1: pm_addr=pc
  3. ret=1 and stack_level>0: pm_addr=top of stack
  4. ret=1 and stack_level=0: pm_addr=pc+1
  5. call=1: pm_addr=T
  6. jmp=1: pm_addr=T
  7. jmp_nz=1 and dont_jmp=0: pm_addr=T
  8. otherwise: pm_addr=pc+1
- Increment: pc+1 computed modulo 2^ADDR_W. pc=all-ones wraps to 0, with no flag.
- Stack: LIFO of STACK_DEPTH entries, each ADDR_W wide. Updates on clock edge only, and only when sync_reset_n=1 and hold=0.
  - call, level<DEPTH: write pc+1 (wrapped) at index level; level+1.
  - call, level=DEPTH: no push, level unchanged, stack_overflow<=1. The branch to T is still taken.
  - ret, level>0: level-1. The entry is not cleared.
  - ret, level=0: no pop, stack_underflow<=1.
  - call and ret both asserted: ret wins (priority above). No push occurs; the pop/underflow rules apply.
  - jmp, jmp_nz: no stack effect.
- Sticky flags: once set, stay 1 until reset. They never self-clear.
- Reset (sync_reset_n=0 at a rising edge):
  - pc=0, stack_level=0, stack_overflow=0, stack_underflow=0.
  - Stack contents are don't-care.
  - from_PS=0 after the edge.
  - pm_addr=0 while reset is asserted, regardless of other inputs.
- Reset mid-call/ret: reset wins; no push or pop occurs on that edge.
- Hold with jmp/call/ret asserted: all ignored for that cycle. The decoder must re-present them after hold drops.
- Latency:
  - Control input to pm_addr: 0 cycles (combinational).
  - pm_addr to pc: 1 cycle.
  - Pushed address readable by ret on the cycle after the call edge.
- Every output is defined from the first edge with sync_reset_n=0. No X may propagate from the uninitialised stack to pm_addr while stack_level=0.

Test Plan:
1. Reset then free-run, defaults: hold sync_reset_n=0 for 2 cycles, then release with all controls 0 -> pc sequence 0,1,2,3. At pc=255, next pc=0 with flags 0.
2. Jumps: at pc=5, jmp=1, jmp_addr=4'hA -> pm_addr=8'hA0 same cycle, pc=8'hA0 next. jmp_nz=1, dont_jmp=1 at pc=8'hA0 -> pc=8'hA1. jmp_nz=1, dont_jmp=0, jmp_addr=3 -> pc=8'h30.
3. Call/return: at pc=8'h12, call=1, jmp_addr=4 -> pc=8'h40, stack_level=1. Run 3 cycles to pc=8'h43. ret=1 -> pc=8'h13, stack_level=0.
4. Overflow/underflow, STACK_DEPTH=4: 5 consecutive calls -> level stays 4, stack_overflow=1, PC still branches on the 5th. 4 rets return in LIFO order. A 5th ret -> pc=previous+1, stack_underflow=1. Both flags stay 1 until reset.
5. Hold and priorities:
   - hold=1 with jmp=1 for 3 cycles at pc=8'h20 -> pc stays 8'h20, level unchanged.
   - call=1 and ret=1 with level=1 -> pop wins, level=0.
   - sync_reset_n=0 asserted together with call -> pc=0, level=0, no push.
6. Parametrised build ADDR_W=10, JMP_W=3, STACK_DEPTH=2: jmp_addr=3'b101 -> pm_addr=10'h280. pc wraps 1023->0. A third nested call sets stack_overflow.

Source files
------------

// File: rtl/program_sequencer_stack.sv
// Program sequencer with a hardware call/return stack and a stall input.
// pm_addr is the combinational next address; pc registers it on every edge.
module program_sequencer_stack #(
  parameter int ADDR_W      = 8,
  parameter int JMP_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               sync_reset_n,
  input  logic [JMP_W-1:0]                   jmp_addr,
  input  logic                               jmp,
  input  logic                               jmp_nz,
  input  logic                               dont_jmp,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               hold,
  output logic [ADDR_W-1:0]                  pm_addr,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  from_PS,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] top;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = ADDR_W'(jmp_addr) << (ADDR_W - JMP_W);

  // Top-of-stack is selected by comparing against the level, so an empty
  // stack never routes uninitialised entries toward pm_addr.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    pm_addr = pc_inc;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!sync_reset_n) begin
      pm_addr = '0;
    end else if (hold) begin
      pm_addr = pc_q;
    end else if (ret) begin
      if (level_q != '0) begin
        pm_addr = top;
        level_d = level_q - LVL_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (call) begin
      pm_addr = target;
      if (level_q != LVL_W'(STACK_DEPTH)) begin
        push    = 1'b1;
        level_d = level_q + LVL_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      pm_addr = target;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      pc_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pm_addr;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents carry no reset; validity is tracked solely by level_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && level_q == LVL_W'(i)) stack_q[i] <= pc_inc;
    end
  end

  assign pc              = pc_q;
  assign from_PS         = pc_q;
  assign stack_level     = level_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Drives a default build and a 10/3/2 build with shared controls and compares
// both against a queue-based reference model of the sequencer rules.
module tb_program_sequencer_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, hold, ret, call, jmp, jnz, dj;
  logic [3:0] jaA;
  logic [2:0] jaB;

  logic [7:0] pmA, pcA, fpA;
  logic [2:0] lvlA;
  logic       ovfA, unfA;
  logic [9:0] pmB, pcB, fpB;
  logic [1:0] lvlB;
  logic       ovfB, unfB;

  program_sequencer_stack #(.ADDR_W(8), .JMP_W(4), .STACK_DEPTH(4)) dutA (
    .clk(clk), .sync_reset_n(rstn), .jmp_addr(jaA), .jmp(jmp), .jmp_nz(jnz),
    .dont_jmp(dj), .call(call), .ret(ret), .hold(hold), .pm_addr(pmA),
    .pc(pcA), .from_PS(fpA), .stack_level(lvlA), .stack_overflow(ovfA),
    .stack_underflow(unfA)
  );

  program_sequencer_stack #(.ADDR_W(10), .JMP_W(3), .STACK_DEPTH(2)) dutB (
    .clk(clk), .sync_reset_n(rstn), .jmp_addr(jaB), .jmp(jmp), .jmp_nz(jnz),
    .dont_jmp(dj), .call(call), .ret(ret), .hold(hold), .pm_addr(pmB),
    .pc(pcB), .from_PS(fpB), .stack_level(lvlB), .stack_overflow(ovfB),
    .stack_underflow(unfB)
  );

  int total = 0;
  int bad   = 0;

  int mPcA = 0, mOvfA = 0, mUnfA = 0;
  int mPcB = 0, mOvfB = 0, mUnfB = 0;
  int qA[$];
  int qB[$];
  bit started = 0;

  function automatic int modelPm(int aw, int jw, int curPc, int lvl, int tos,
                                 int ja);
    int mask = (1 << aw) - 1;
    if (!rstn) return 0;
    if (hold) return curPc;
    if (ret) return (lvl > 0) ? tos : ((curPc + 1) & mask);
    if (call || jmp || (jnz && !dj)) return ja << (aw - jw);
    return (curPc + 1) & mask;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit h, input bit rt,
                               input bit c, input bit j, input bit jn,
                               input bit d, input int a, input int b);
    rstn = r; hold = h; ret = rt; call = c; jmp = j; jnz = jn; dj = d;
    jaA = 4'(a); jaB = 3'(b);
  endtask

  task automatic checkOutput();
    int expA, expB;
    #1;
    expA = modelPm(8, 4, mPcA, qA.size(), (qA.size() > 0) ? qA[$] : 0, int'(jaA));
    expB = modelPm(10, 3, mPcB, qB.size(), (qB.size() > 0) ? qB[$] : 0, int'(jaB));
    if (started || !rstn) begin
      check("pmA", 32'(pmA), 32'(expA));
      check("pmB", 32'(pmB), 32'(expB));
    end
    @(posedge clk);
    if (!rstn) begin
      qA.delete(); qB.delete();
      mOvfA = 0; mUnfA = 0; mOvfB = 0; mUnfB = 0;
    end else if (!hold) begin
      if (ret) begin
        if (qA.size() > 0) void'(qA.pop_back()); else mUnfA = 1;
        if (qB.size() > 0) void'(qB.pop_back()); else mUnfB = 1;
      end else if (call) begin
        if (qA.size() < 4) qA.push_back((mPcA + 1) & 255); else mOvfA = 1;
        if (qB.size() < 2) qB.push_back((mPcB + 1) & 1023); else mOvfB = 1;
      end
    end
    mPcA = expA;
    mPcB = expB;
    if (!rstn) started = 1;
    #1;
    if (started) begin
      check("pcA", 32'(pcA), 32'(mPcA));
      check("fromPsA", 32'(fpA), 32'(mPcA));
      check("levelA", 32'(lvlA), 32'(qA.size()));
      check("ovfA", 32'(ovfA), 32'(mOvfA));
      check("unfA", 32'(unfA), 32'(mUnfA));
      check("pcB", 32'(pcB), 32'(mPcB));
      check("fromPsB", 32'(fpB), 32'(mPcB));
      check("levelB", 32'(lvlB), 32'(qB.size()));
      check("ovfB", 32'(ovfB), 32'(mOvfB));
      check("unfB", 32'(unfB), 32'(mUnfB));
    end
  endtask

  task automatic step(input bit r, input bit h, input bit rt, input bit c,
                      input bit j, input bit jn, input bit d, input int a,
                      input int b);
    applyStimulus(r, h, rt, c, j, jn, d, a, b);
    checkOutput();
  endtask

  initial begin
    // Reset and free run.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("pcAfterReset", 32'(pcA), 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("pcFreeRun", 32'(pcA), 32'h5);
    // Jumps.
    step(1, 0, 0, 0, 1, 0, 0, 4'hA, 3'h5);
    check("pcJmpA0", 32'(pcA), 32'hA0);
    check("pcJmpB280", 32'(pcB), 32'h280);
    step(1, 0, 0, 0, 0, 1, 1, 4'h3, 3'h1);
    check("pcJnzNotTaken", 32'(pcA), 32'hA1);
    step(1, 0, 0, 0, 0, 1, 0, 4'h3, 3'h1);
    check("pcJnzTaken", 32'(pcA), 32'h30);
    // Wrap at all-ones for both builds.
    step(1, 0, 0, 0, 1, 0, 0, 4'hF, 3'h7);
    for (int i = 0; i < 128; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Call/return, overflow and underflow.
    step(1, 0, 0, 0, 1, 0, 0, 4'h1, 3'h1);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0, 0, 4 + i, i);
    check("ovfAfterFiveCalls", 32'(ovfA), 32'h1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    check("unfAfterFiveRets", 32'(unfA), 32'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Hold with jump, call+ret priority, reset with call.
    step(1, 0, 0, 0, 1, 0, 0, 4'h2, 3'h2);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0, 0, 4'h9, 3'h3);
    check("pcHeld", 32'(pcA), 32'h20);
    step(1, 0, 0, 1, 0, 0, 0, 4'h6, 3'h6);
    step(1, 0, 1, 1, 0, 0, 0, 4'h7, 3'h7);
    check("levelCallRet", 32'(lvlA), 32'h0);
    step(1, 0, 0, 1, 0, 0, 0, 4'h6, 3'h6);
    step(0, 0, 0, 1, 0, 0, 0, 4'h5, 3'h5);
    check("levelResetCall", 32'(lvlA), 32'h0);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) != 0, ($urandom % 8) == 0, ($urandom % 5) == 0,
           ($urandom % 5) == 0, ($urandom % 8) == 0, ($urandom % 5) == 0,
           $urandom % 2, int'($urandom % 16), int'($urandom % 8));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
